ethernet_reply_scheduler: RTL
=============================

Name: ethernet_reply_scheduler

Overview:
Shares the single header reply builder between three reply requesters: ARP, ICMP and UDP.
- Arbitrates pending 42-byte request headers and issues each winner to the builder as a one-cycle valid pulse with a one-hot class strobe.
- Captures the built reply and presents it to the TX header path with a valid/ready handshake.
- Sits between the RX classifiers and the reply builder / TX framer, and keeps per-class served counters plus a builder-timeout counter.

Parameters:
HEAD_W, 336, header width in bits (42 bytes)
ARP_PRIORITY, 1, 1 = ARP always wins when valid; 0 = pure round-robin
BUILD_TIMEOUT, 15, max WAIT cycles for builder ready before the request is dropped
CNT_W, 16, width of the per-class served counters

Ports:
i_clk  input  1  clock
i_reset_n  input  1  asynchronous active-low reset
i_arp_req_valid  input  1  ARP request pending
o_arp_req_ready  output  1  ARP request accepted this cycle
i_arp_head  input  HEAD_W  ARP request header
i_icmp_req_valid / o_icmp_req_ready / i_icmp_head  in/out/in  1/1/HEAD_W  same for ICMP
i_udp_req_valid / o_udp_req_ready / i_udp_head  in/out/in  1/1/HEAD_W  same for UDP
o_bld_head_valid  output  1  one-cycle issue pulse to builder
o_bld_arp_valid, o_bld_icmp_valid, o_bld_udp_valid  output  1 each  one-hot class, meaningful only with o_bld_head_valid
o_bld_head  output  HEAD_W  header to builder
i_bld_reply  input  HEAD_W  built reply header
i_bld_reply_ready  input  1  builder reply valid
o_tx_valid  output  1  reply header available
i_tx_ready  input  1  TX accepts
o_tx_head  output  HEAD_W  reply header
o_tx_class  output  2  0=ARP, 1=ICMP, 2=UDP
o_cnt_arp, o_cnt_icmp, o_cnt_udp  output  CNT_W each  replies delivered, saturating
o_timeout_cnt  output  8  builder timeouts, saturating

Behaviour:
- Reset (async, i_reset_n=0):
  - State IDLE; all outputs 0; o_bld_head and o_tx_head 0.
  - Round-robin pointer set to "last grant = UDP", so ARP is checked first.
  - Reset mid-operation discards any in-flight request; no counter increments.
- FSM states: IDLE, ISSUE, WAIT, SEND.
- IDLE:
  - Winner chosen combinationally from valids. If ARP_PRIORITY=1 and ARP is valid, ARP wins. Otherwise round-robin starting at the class after the last grant, in order ARP→ICMP→UDP→ARP.
  - Winner's o_*_req_ready=1 in the same cycle. Ready depends combinationally on valid; no other ready is asserted.
  - On accept: latch head and class, go to ISSUE. With no valid, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - o_bld_head_valid=1, matching o_bld_*_valid=1, o_bld_head=latched head.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - All o_bld_* are 0.
  - If i_bld_reply_ready=1: capture i_bld_reply into o_tx_head, set o_tx_class, go to SEND.
  - Else increment the timeout counter. When it reaches BUILD_TIMEOUT: drop the request, o_timeout_cnt+1 (saturate at 255), update the RR pointer, go to IDLE.
  - i_bld_reply_ready outside WAIT is ignored.
- SEND:
  - o_tx_valid=1; o_tx_head and o_tx_class stay stable until the handshake.
  - On i_tx_ready=1: matching counter +1 (saturate at 2^CNT_W-1), RR pointer = this class, o_tx_valid=0 next cycle, go to IDLE.
  - No new request is accepted while busy: one request in flight.
- Latency: accept at cycle N, builder pulse at N+1, builder ready at N+2 (registered builder), o_tx_valid at N+3. Minimum back-to-back spacing is 4 cycles when i_tx_ready is tied 1.
- Simultaneous valids: exactly one grant per IDLE cycle. Unserved requesters must hold valid and head stable.

Decomposition:
- Shared package holds:
  - class encodings CLS_ARP=0, CLS_ICMP=1, CLS_UDP=2
  - HEAD_W=336
  - FSM state encodings
- One natural sub-module: eth_rr_arbiter3. Three requests, priority-override input and last-grant pointer in; one-hot grant out; purely combinational.

Test Plan:
1. Reset release, ARP valid with head=H1; builder model returns H1^1 one cycle after the pulse; i_tx_ready=1 → o_arp_req_ready at N, o_bld_arp_valid pulse at N+1, o_tx_valid with o_tx_head=H1^1 and o_tx_class=0 at N+3, o_cnt_arp=1.
2. ICMP and UDP held valid continuously, ARP_PRIORITY=1, no ARP → grants alternate ICMP, UDP, ICMP, UDP; after 4 replies o_cnt_icmp=2 and o_cnt_udp=2.
3. All three valid, ARP_PRIORITY=1 → ARP is granted every IDLE cycle while valid; ICMP/UDP ready stays 0.
4. Builder model never asserts ready → 15 WAIT cycles, o_timeout_cnt=1, back in IDLE, o_tx_valid never asserted.
5. i_tx_ready held 0 for 10 cycles in SEND → o_tx_valid and o_tx_head stay stable, no req_ready asserted; i_tx_ready=1 → one counter increment.
6. Assert i_reset_n=0 during WAIT, then release → all outputs 0, counters 0; the next request is granted normally with ARP checked first.

Source files
------------

// File: rtl/ethernet_reply_scheduler_pkg.sv
// Shared definitions for the Ethernet reply scheduler.
//   - HEAD_W  : request/reply header width (42 bytes)
//   - cls_e   : requester class encoding, also driven on o_tx_class
//   - state_e : scheduler FSM states
package ethernet_reply_scheduler_pkg;

  localparam int unsigned HEAD_W = 336;

  typedef enum logic [1:0] {
    CLS_ARP  = 2'd0,
    CLS_ICMP = 2'd1,
    CLS_UDP  = 2'd2
  } cls_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StSend
  } state_e;

endpackage

// File: rtl/eth_rr_arbiter3.sv
// Three-way combinational arbiter with optional ARP priority override.
//   req_i      : request vector, bit 0 = ARP, bit 1 = ICMP, bit 2 = UDP
//   prio_arp_i : when set, a pending ARP request always wins
//   last_i     : class granted last; the search starts at the next class
//   gnt_o      : one-hot grant, all zero when nothing is requested
module eth_rr_arbiter3
  import ethernet_reply_scheduler_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic       prio_arp_i,
  input  cls_e       last_i,
  output logic [2:0] gnt_o
);

  always_comb begin
    gnt_o = 3'b000;
    if (prio_arp_i && req_i[0]) begin
      gnt_o = 3'b001;
    end else begin
      unique case (last_i)
        CLS_ARP: begin
          if      (req_i[1]) gnt_o = 3'b010;
          else if (req_i[2]) gnt_o = 3'b100;
          else if (req_i[0]) gnt_o = 3'b001;
        end
        CLS_ICMP: begin
          if      (req_i[2]) gnt_o = 3'b100;
          else if (req_i[0]) gnt_o = 3'b001;
          else if (req_i[1]) gnt_o = 3'b010;
        end
        default: begin
          if      (req_i[0]) gnt_o = 3'b001;
          else if (req_i[1]) gnt_o = 3'b010;
          else if (req_i[2]) gnt_o = 3'b100;
        end
      endcase
    end
  end

endmodule

// File: rtl/ethernet_reply_scheduler.sv
// Shares one reply header builder between ARP, ICMP and UDP requesters.
//   i_*_req_valid/o_*_req_ready/i_*_head : per-class request handshake and header
//   o_bld_*                              : one-cycle issue pulse, class strobe, header
//   i_bld_reply/i_bld_reply_ready        : built reply from the builder
//   o_tx_valid/i_tx_ready/o_tx_head/o_tx_class : reply towards the TX framer
//   o_cnt_*/o_timeout_cnt                : saturating served / timeout counters
// One request is in flight at a time: IDLE -> ISSUE -> WAIT -> SEND -> IDLE.
module ethernet_reply_scheduler
  import ethernet_reply_scheduler_pkg::*;
#(
  parameter int unsigned ARP_PRIORITY  = 1,
  parameter int unsigned BUILD_TIMEOUT = 15,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_arp_req_valid,
  output logic              o_arp_req_ready,
  input  logic [HEAD_W-1:0] i_arp_head,
  input  logic              i_icmp_req_valid,
  output logic              o_icmp_req_ready,
  input  logic [HEAD_W-1:0] i_icmp_head,
  input  logic              i_udp_req_valid,
  output logic              o_udp_req_ready,
  input  logic [HEAD_W-1:0] i_udp_head,
  output logic              o_bld_head_valid,
  output logic              o_bld_arp_valid,
  output logic              o_bld_icmp_valid,
  output logic              o_bld_udp_valid,
  output logic [HEAD_W-1:0] o_bld_head,
  input  logic [HEAD_W-1:0] i_bld_reply,
  input  logic              i_bld_reply_ready,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic [HEAD_W-1:0] o_tx_head,
  output logic [1:0]        o_tx_class,
  output logic [CNT_W-1:0]  o_cnt_arp,
  output logic [CNT_W-1:0]  o_cnt_icmp,
  output logic [CNT_W-1:0]  o_cnt_udp,
  output logic [7:0]        o_timeout_cnt
);

  // Last WAIT count before the request is abandoned.
  localparam logic [15:0] TmoLast = 16'(BUILD_TIMEOUT - 1);

  state_e             state_q, state_d;
  cls_e               cls_q, cls_d;
  cls_e               last_q, last_d;
  cls_e               tx_cls_q, tx_cls_d;
  logic [HEAD_W-1:0]  head_q, head_d;
  logic [HEAD_W-1:0]  tx_head_q, tx_head_d;
  logic [15:0]        tmo_q, tmo_d;
  logic [CNT_W-1:0]   cnt_arp_q, cnt_arp_d;
  logic [CNT_W-1:0]   cnt_icmp_q, cnt_icmp_d;
  logic [CNT_W-1:0]   cnt_udp_q, cnt_udp_d;
  logic [7:0]         tocnt_q, tocnt_d;
  logic [2:0]         gnt;
  logic               idle;

  eth_rr_arbiter3 u_arb (
    .req_i      ({i_udp_req_valid, i_icmp_req_valid, i_arp_req_valid}),
    .prio_arp_i (ARP_PRIORITY != 0),
    .last_i     (last_q),
    .gnt_o      (gnt)
  );

  assign idle = (state_q == StIdle);

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    last_d     = last_q;
    tx_cls_d   = tx_cls_q;
    head_d     = head_q;
    tx_head_d  = tx_head_q;
    tmo_d      = tmo_q;
    cnt_arp_d  = cnt_arp_q;
    cnt_icmp_d = cnt_icmp_q;
    cnt_udp_d  = cnt_udp_q;
    tocnt_d    = tocnt_q;
    unique case (state_q)
      StIdle: begin
        if (gnt != 3'b000) begin
          state_d = StIssue;
          unique case (gnt)
            3'b001:  begin head_d = i_arp_head;  cls_d = CLS_ARP;  end
            3'b010:  begin head_d = i_icmp_head; cls_d = CLS_ICMP; end
            default: begin head_d = i_udp_head;  cls_d = CLS_UDP;  end
          endcase
        end
      end
      StIssue: begin
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (i_bld_reply_ready) begin
          tx_head_d = i_bld_reply;
          tx_cls_d  = cls_q;
          state_d   = StSend;
        end else if (tmo_q == TmoLast) begin
          // Drop the request; the dropped class still counts as the last grant.
          last_d  = cls_q;
          state_d = StIdle;
          if (tocnt_q != 8'hFF) tocnt_d = tocnt_q + 8'd1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      StSend: begin
        if (i_tx_ready) begin
          last_d  = tx_cls_q;
          state_d = StIdle;
          unique case (tx_cls_q)
            CLS_ARP:  if (cnt_arp_q  != '1) cnt_arp_d  = cnt_arp_q  + 1'b1;
            CLS_ICMP: if (cnt_icmp_q != '1) cnt_icmp_d = cnt_icmp_q + 1'b1;
            default:  if (cnt_udp_q  != '1) cnt_udp_d  = cnt_udp_q  + 1'b1;
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= StIdle;
      cls_q      <= CLS_ARP;
      last_q     <= CLS_UDP;  // ARP is checked first after reset
      tx_cls_q   <= CLS_ARP;
      head_q     <= '0;
      tx_head_q  <= '0;
      tmo_q      <= '0;
      cnt_arp_q  <= '0;
      cnt_icmp_q <= '0;
      cnt_udp_q  <= '0;
      tocnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      last_q     <= last_d;
      tx_cls_q   <= tx_cls_d;
      head_q     <= head_d;
      tx_head_q  <= tx_head_d;
      tmo_q      <= tmo_d;
      cnt_arp_q  <= cnt_arp_d;
      cnt_icmp_q <= cnt_icmp_d;
      cnt_udp_q  <= cnt_udp_d;
      tocnt_q    <= tocnt_d;
    end
  end

  // Ready is combinational on valid so a requester is accepted in the same cycle.
  assign o_arp_req_ready  = idle & gnt[0];
  assign o_icmp_req_ready = idle & gnt[1];
  assign o_udp_req_ready  = idle & gnt[2];

  assign o_bld_head_valid = (state_q == StIssue);
  assign o_bld_arp_valid  = o_bld_head_valid && (cls_q == CLS_ARP);
  assign o_bld_icmp_valid = o_bld_head_valid && (cls_q == CLS_ICMP);
  assign o_bld_udp_valid  = o_bld_head_valid && (cls_q == CLS_UDP);
  assign o_bld_head       = head_q;

  assign o_tx_valid    = (state_q == StSend);
  assign o_tx_head     = tx_head_q;
  assign o_tx_class    = tx_cls_q;
  assign o_cnt_arp     = cnt_arp_q;
  assign o_cnt_icmp    = cnt_icmp_q;
  assign o_cnt_udp     = cnt_udp_q;
  assign o_timeout_cnt = tocnt_q;

endmodule
